// File: rtl/nfc_status_poller.sv
// rtl/nfc_status_poller.sv - ReadStatus polling sequencer for one NAND way
//
// Repeatedly issues a ReadStatus command to the selected way, captures the
// first status byte returned, and stops when the ready bit (status[6]) is set.
// Between polls it idles for PollGap cycles. With NFC_POLL_TIMEOUT_EN defined
// the sequencer also gives up after MaxPolls reads and reports oTimeout.
//
// Ports:
//   iSystemClock, iReset          clock, asynchronous active-high reset
//   iPollValid/oPollReady         poll-request handshake
//   iPollWay/iPollEnhanced/
//   iPollRowAddr                  request payload, latched on acceptance
//   oOpcode..oCMDValid/iCMDReady  ReadStatus command toward the command block
//   oWaySelect                    latched way while busy, zero when idle
//   iCmdLastStep                  command block completion pulse
//   iReadData/iReadValid/
//   oReadReady                    status-byte stream (low byte is the status)
//   oDone/oStatus/oFail/
//   oTimeout/oPollCount           result, held until the next request
module nfc_status_poller #(
  parameter int NumberOfWays = 4,
  parameter int PollGap      = 16,
  parameter int MaxPolls     = 1024
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iPollValid,
  output logic                    oPollReady,
  input  logic [NumberOfWays-1:0] iPollWay,
  input  logic                    iPollEnhanced,
  input  logic [23:0]             iPollRowAddr,
  output logic [5:0]              oOpcode,
  output logic [4:0]              oTargetID,
  output logic [4:0]              oSourceID,
  output logic [31:0]             oAddress,
  output logic [15:0]             oLength,
  output logic                    oCMDValid,
  input  logic                    iCMDReady,
  output logic [NumberOfWays-1:0] oWaySelect,
  input  logic                    iCmdLastStep,
  input  logic [15:0]             iReadData,
  input  logic                    iReadValid,
  output logic                    oReadReady,
  output logic                    oDone,
  output logic [7:0]              oStatus,
  output logic                    oFail,
  output logic                    oTimeout,
  output logic [15:0]             oPollCount
);

`ifdef NFC_POLL_TIMEOUT_EN
  localparam logic TimeoutEnable = 1'b1;
`else
  localparam logic TimeoutEnable = 1'b0;
`endif
  localparam logic [15:0] PollLimit = 16'(MaxPolls);
  localparam logic [15:0] GapLast   = 16'(PollGap - 1);

  typedef enum logic [2:0] {
    sIdle,
    sIssue,
    sWait,
    sEval,
    sGap,
    sDone
  } state_t;

  state_t                  state;
  state_t                  nextState;
  logic [NumberOfWays-1:0] way;
  logic                    enhanced;
  logic [23:0]             rowAddr;
  logic                    dataSeen;
  logic                    lastSeen;
  logic [15:0]             gapCount;
  logic [15:0]             pollCount;
  logic [7:0]              status;
  logic                    fail;
  logic                    timeout;

  logic [15:0]             countInc;
  logic                    dataSeenNow;
  logic                    lastSeenNow;
  logic                    timeoutHit;
  logic                    unusedReadHigh;

  // Only the low byte of a status beat carries the status register.
  assign unusedReadHigh = ^iReadData[15:8];

  always_comb begin
    countInc    = (pollCount == 16'hFFFF) ? pollCount : pollCount + 16'd1;
    // Flags including the current cycle, so data and last-step arriving
    // together (or in either order) both leave WAIT exactly once.
    dataSeenNow = dataSeen | iReadValid;
    lastSeenNow = lastSeen | iCmdLastStep;
    timeoutHit  = TimeoutEnable && (countInc == PollLimit);

    nextState = state;
    case (state)
      sIdle:   if (iPollValid) nextState = sIssue;
      sIssue:  if (iCMDReady) nextState = sWait;
      sWait:   if (dataSeenNow && lastSeenNow) nextState = sEval;
      sEval:   nextState = (status[6] || timeoutHit) ? sDone : sGap;
      sGap:    if (gapCount == GapLast) nextState = sIssue;
      sDone:   nextState = sIdle;
      default: nextState = sIdle;
    endcase
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state <= sIdle;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      way       <= '0;
      enhanced  <= 1'b0;
      rowAddr   <= '0;
      dataSeen  <= 1'b0;
      lastSeen  <= 1'b0;
      gapCount  <= '0;
      pollCount <= '0;
      status    <= '0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        sIdle: begin
          if (iPollValid) begin
            way       <= iPollWay;
            enhanced  <= iPollEnhanced;
            rowAddr   <= iPollRowAddr;
            pollCount <= '0;
            status    <= '0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        sIssue: begin
          dataSeen <= 1'b0;
          lastSeen <= 1'b0;
        end
        sWait: begin
          // Keep the first beat; any further beats are drained and dropped.
          if (iReadValid && !dataSeen) status <= iReadData[7:0];
          dataSeen <= dataSeenNow;
          lastSeen <= lastSeenNow;
        end
        sEval: begin
          pollCount <= countInc;
          gapCount  <= '0;
          if (status[6]) begin
            fail <= status[0];
          end else if (timeoutHit) begin
            timeout <= 1'b1;
          end
        end
        sGap: begin
          gapCount <= gapCount + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign oPollReady = (state == sIdle);
  assign oCMDValid  = (state == sIssue);
  assign oOpcode    = oCMDValid ? 6'b000111 : 6'b000000;
  assign oTargetID  = oCMDValid ? {4'b0010, enhanced} : 5'b00000;
  assign oSourceID  = 5'b00000;
  assign oLength    = oCMDValid ? 16'd1 : 16'd0;
  assign oAddress   = (oCMDValid && enhanced) ? {8'h00, rowAddr} : 32'd0;
  assign oWaySelect = (state == sIdle) ? '0 : way;
  assign oReadReady = (state == sWait);
  assign oDone      = (state == sDone);
  assign oStatus    = status;
  assign oFail      = fail;
  assign oTimeout   = timeout;
  assign oPollCount = pollCount;

endmodule

// File: tb/tb_nfc_status_poller.sv
// tb/tb_nfc_status_poller.sv - self-checking bench for nfc_status_poller
module tb_nfc_status_poller;
  localparam int Ways  = 4;
  localparam int Gap   = 3;
  localparam int Limit = 4;
`ifdef NFC_POLL_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic            iSystemClock;
  logic            iReset;
  logic            iPollValid;
  logic            oPollReady;
  logic [Ways-1:0] iPollWay;
  logic            iPollEnhanced;
  logic [23:0]     iPollRowAddr;
  logic [5:0]      oOpcode;
  logic [4:0]      oTargetID;
  logic [4:0]      oSourceID;
  logic [31:0]     oAddress;
  logic [15:0]     oLength;
  logic            oCMDValid;
  logic            iCMDReady;
  logic [Ways-1:0] oWaySelect;
  logic            iCmdLastStep;
  logic [15:0]     iReadData;
  logic            iReadValid;
  logic            oReadReady;
  logic            oDone;
  logic [7:0]      oStatus;
  logic            oFail;
  logic            oTimeout;
  logic [15:0]     oPollCount;

  nfc_status_poller #(.NumberOfWays(Ways), .PollGap(Gap), .MaxPolls(Limit)) dut (
    .iSystemClock(iSystemClock), .iReset(iReset),
    .iPollValid(iPollValid), .oPollReady(oPollReady),
    .iPollWay(iPollWay), .iPollEnhanced(iPollEnhanced), .iPollRowAddr(iPollRowAddr),
    .oOpcode(oOpcode), .oTargetID(oTargetID), .oSourceID(oSourceID),
    .oAddress(oAddress), .oLength(oLength), .oCMDValid(oCMDValid),
    .iCMDReady(iCMDReady), .oWaySelect(oWaySelect), .iCmdLastStep(iCmdLastStep),
    .iReadData(iReadData), .iReadValid(iReadValid), .oReadReady(oReadReady),
    .oDone(oDone), .oStatus(oStatus), .oFail(oFail), .oTimeout(oTimeout),
    .oPollCount(oPollCount)
  );

  initial iSystemClock = 1'b0;
  always #5 iSystemClock = ~iSystemClock;

  int cycle = 0;
  int doneSeen = 0;
  int cmdSeen = 0;
  int compared = 0;
  int mismatched = 0;

  always @(posedge iSystemClock) begin
    cycle++;
    if (oDone === 1'b1) doneSeen++;
    if (oCMDValid === 1'b1 && iCMDReady === 1'b1) cmdSeen++;
  end

  typedef struct {
    logic [3:0]  way;
    logic        enh;
    logic [23:0] row;
    logic [31:0] st;
    int          nSt;
    int          dD;
    int          dL;
    int          beats;
    logic [7:0]  expStatus;
    logic        expFail;
    int          expCount;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the poll sequence ends at the first ready status, or at the
  // poll limit when the timeout feature is built in.
  function automatic void model(input logic [7:0] q[$], output int polls,
                                output logic [7:0] st, output logic fail, output logic to);
    polls = 0; st = 8'h00; fail = 1'b0; to = 1'b0;
    foreach (q[i]) begin
      polls = i + 1;
      st = q[i];
      if (q[i][6]) begin
        fail = q[i][0];
        return;
      end
      if (TimeoutOn && polls == Limit) begin
        to = 1'b1;
        return;
      end
    end
  endfunction

  task automatic request(input logic [3:0] way, input logic enh, input logic [23:0] row);
    @(negedge iSystemClock);
    check("ready before request", 32'(oPollReady), 32'd1);
    check("way select idle", 32'(oWaySelect), 32'd0);
    iPollValid = 1'b1; iPollWay = way; iPollEnhanced = enh; iPollRowAddr = row;
    @(negedge iSystemClock);
    iPollValid = 1'b0;
    iPollWay = 4'($urandom); iPollEnhanced = 1'($urandom); iPollRowAddr = 24'($urandom);
  endtask

  // Serves one ReadStatus command: status beat at offset dD, last-step at dL
  // (offsets in cycles after the handshake). Returns at the EVAL cycle.
  task automatic serveOne(input logic [7:0] st, input int dD, input int dL, input int beats,
                          input logic [3:0] way, input logic enh, input logic [23:0] row,
                          output int at);
    bit got;
    int m;
    got = 0;
    m = (dD > dL) ? dD : dL;
    for (int k = 0; k < 40; k++) begin
      if (oCMDValid === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge iSystemClock);
    end
    at = cycle;
    if (!got) begin
      check("command issued", 32'd0, 32'd1);
      return;
    end
    check("opcode", 32'(oOpcode), 32'h07);
    check("target id", 32'(oTargetID), 32'({4'b0010, enh}));
    check("source id", 32'(oSourceID), 32'd0);
    check("length", 32'(oLength), 32'd1);
    check("address", oAddress, enh ? {8'h00, row} : 32'd0);
    check("way select busy", 32'(oWaySelect), 32'(way));
    for (int d = 0; d <= m; d++) begin
      @(negedge iSystemClock);
      if (d == 0) begin
        check("cmd valid one cycle", 32'(oCMDValid), 32'd0);
        check("read ready in wait", 32'(oReadReady), 32'd1);
      end
      iReadValid   = (d >= dD) && (d < dD + beats);
      iReadData    = (d == dD) ? {8'($urandom), st} : 16'($urandom);
      iCmdLastStep = (d == dL);
    end
    @(negedge iSystemClock);
    iReadValid = 1'b0; iCmdLastStep = 1'b0; iReadData = 16'h0000;
    check("read ready off after wait", 32'(oReadReady), 32'd0);
  endtask

  task automatic waitDone(input logic [7:0] expStatus, input logic expFail, input logic expTo,
                          input int expCount);
    bit got;
    got = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge iSystemClock);
      if (oDone === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("done pulse seen", 32'(got), 32'd1);
    check("status", 32'(oStatus), 32'(expStatus));
    check("fail", 32'(oFail), 32'(expFail));
    check("timeout", 32'(oTimeout), 32'(expTo));
    check("poll count", 32'(oPollCount), 32'(expCount));
    @(negedge iSystemClock);
    check("done one cycle", 32'(oDone), 32'd0);
    check("ready after done", 32'(oPollReady), 32'd1);
    check("status held", 32'(oStatus), 32'(expStatus));
    check("count held", 32'(oPollCount), 32'(expCount));
  endtask

  task automatic runScenario(input logic [3:0] way, input logic enh, input logic [23:0] row,
                             input logic [7:0] q[$], input int dD, input int dL, input int beats,
                             input logic [7:0] expStatus, input logic expFail, input logic expTo,
                             input int expCount);
    int prevAt, at, m, cmdBase, doneBase;
    m = (dD > dL) ? dD : dL;
    prevAt = 0;
    cmdBase = cmdSeen;
    doneBase = doneSeen;
    request(way, enh, row);
    for (int i = 0; i < expCount; i++) begin
      serveOne(q[i], dD, dL, beats, way, enh, row, at);
      if (i > 0) check("command spacing", 32'(at - prevAt), 32'(m + 3 + Gap));
      prevAt = at;
    end
    waitDone(expStatus, expFail, expTo, expCount);
    check("commands per request", 32'(cmdSeen - cmdBase), 32'(expCount));
    check("done pulses per request", 32'(doneSeen - doneBase), 32'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    int polls, at, doneBase;
    logic [7:0] mst;
    logic mfail, mto;
    logic [3:0] w;
    logic e;
    logic [23:0] r;
    int dD, dL;

    tbl[0] = '{4'b0010, 1'b0, 24'h000000, 32'h000000E0, 1, 0, 0, 1, 8'hE0, 1'b0, 1};
    tbl[1] = '{4'b0001, 1'b1, 24'h012345, 32'h00410000, 3, 0, 0, 1, 8'h41, 1'b1, 3};
    tbl[2] = '{4'b0100, 1'b0, 24'hABCDEF, 32'h000000C3, 1, 0, 2, 2, 8'hC3, 1'b1, 1};
    tbl[3] = '{4'b1000, 1'b1, 24'hFEDCBA, 32'h00000040, 1, 1, 1, 1, 8'h40, 1'b0, 1};
    tbl[4] = '{4'b0001, 1'b0, 24'h000001, 32'h00004F00, 2, 3, 0, 1, 8'h4F, 1'b1, 2};

    iReset = 1'b1; iPollValid = 1'b0; iPollWay = '0; iPollEnhanced = 1'b0;
    iPollRowAddr = '0; iCMDReady = 1'b1; iCmdLastStep = 1'b0; iReadData = '0;
    iReadValid = 1'b0;
    repeat (2) @(negedge iSystemClock);
    check("reset poll ready", 32'(oPollReady), 32'd1);
    check("reset cmd valid", 32'(oCMDValid), 32'd0);
    check("reset opcode", 32'(oOpcode), 32'd0);
    check("reset target", 32'(oTargetID), 32'd0);
    check("reset address", oAddress, 32'd0);
    check("reset length", 32'(oLength), 32'd0);
    check("reset way select", 32'(oWaySelect), 32'd0);
    check("reset read ready", 32'(oReadReady), 32'd0);
    check("reset done", 32'(oDone), 32'd0);
    check("reset status", 32'(oStatus), 32'd0);
    check("reset fail", 32'(oFail), 32'd0);
    check("reset timeout", 32'(oTimeout), 32'd0);
    check("reset count", 32'(oPollCount), 32'd0);
    iReset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      q = {};
      for (int j = 0; j < tbl[t].nSt; j++) q.push_back(tbl[t].st[8*j +: 8]);
      runScenario(tbl[t].way, tbl[t].enh, tbl[t].row, q, tbl[t].dD, tbl[t].dL, tbl[t].beats,
                  tbl[t].expStatus, tbl[t].expFail, 1'b0, tbl[t].expCount);
    end

    // Never-ready device.
    q = {};
    for (int j = 0; j < 11; j++) q.push_back(8'h00);
`ifdef NFC_POLL_TIMEOUT_EN
    runScenario(4'b1000, 1'b0, 24'h0, q, 0, 0, 1, 8'h00, 1'b0, 1'b1, Limit);
`else
    doneBase = doneSeen;
    request(4'b1000, 1'b0, 24'h0);
    for (int i = 0; i < 10; i++) serveOne(8'h00, 0, 0, 1, 4'b1000, 1'b0, 24'h0, at);
    @(negedge iSystemClock);
    check("no done without timeout", 32'(doneSeen - doneBase), 32'd0);
    check("count after ten polls", 32'(oPollCount), 32'd10);
    serveOne(8'h40, 0, 0, 1, 4'b1000, 1'b0, 24'h0, at);
    waitDone(8'h40, 1'b0, 1'b0, 11);
`endif

    // Reset while waiting for status.
    doneBase = doneSeen;
    request(4'b0100, 1'b1, 24'h00BEEF);
    @(negedge iSystemClock);
    check("wait before reset", 32'(oReadReady), 32'd1);
    iReadValid = 1'b1; iReadData = 16'h0040;
    iReset = 1'b1;
    @(negedge iSystemClock);
    check("ready after reset", 32'(oPollReady), 32'd1);
    check("no cmd after reset", 32'(oCMDValid), 32'd0);
    check("count cleared by reset", 32'(oPollCount), 32'd0);
    iReset = 1'b0; iReadValid = 1'b0; iReadData = 16'h0000;
    repeat (4) @(negedge iSystemClock);
    check("no done after reset", 32'(doneSeen - doneBase), 32'd0);
    q = {8'hE0};
    runScenario(4'b0010, 1'b0, 24'h0, q, 0, 0, 1, 8'hE0, 1'b0, 1'b0, 1);

    // Request held high across DONE.
    @(negedge iSystemClock);
    iPollValid = 1'b1; iPollWay = 4'b0100; iPollEnhanced = 1'b0; iPollRowAddr = 24'h0;
    @(negedge iSystemClock);
    serveOne(8'h40, 0, 0, 1, 4'b0100, 1'b0, 24'h0, at);
    @(negedge iSystemClock);
    check("held req done", 32'(oDone), 32'd1);
    check("held req busy in done", 32'(oPollReady), 32'd0);
    check("held req single poll", 32'(oPollCount), 32'd1);
    @(negedge iSystemClock);
    check("held req idle", 32'(oPollReady), 32'd1);
    check("held req no cmd in idle", 32'(oCMDValid), 32'd0);
    @(negedge iSystemClock);
    check("held req second issue", 32'(oCMDValid), 32'd1);
    iPollValid = 1'b0;
    serveOne(8'h41, 0, 0, 1, 4'b0100, 1'b0, 24'h0, at);
    waitDone(8'h41, 1'b1, 1'b0, 1);

    // Randomised requests against the reference model.
    for (int n = 0; n < 20; n++) begin
      q = {};
      polls = $urandom_range(1, 6);
      for (int j = 0; j < polls; j++) q.push_back(8'($urandom));
      q[polls-1][6] = 1'b1;
      model(q, polls, mst, mfail, mto);
      w  = 4'(1 << $urandom_range(0, 3));
      e  = 1'($urandom);
      r  = 24'($urandom);
      dD = $urandom_range(0, 3);
      dL = $urandom_range(0, 3);
      runScenario(w, e, r, q, dD, dL, $urandom_range(1, 2), mst, mfail, mto, polls);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nfc_status_poller.md
NFC_STATUS_POLLER -- requirements
Module: nfc_status_poller

Interface
REQ-001 SHALL have parameter NumberOfWays, default 4, one-hot way-select width.
REQ-002 SHALL have parameter PollGap, default 16, idle cycles between consecutive status reads (range 1..65535).
REQ-003 SHALL have parameter MaxPolls, default 1024, status reads before timeout (range 1..65535).
REQ-004 SHALL have port iSystemClock  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port iReset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports iPollValid in 1 / oPollReady out 1, the poll-request handshake.
REQ-007 SHALL have ports iPollWay in NumberOfWays, iPollEnhanced in 1, iPollRowAddr in 24, the request payload.
REQ-008 SHALL have command-side outputs oOpcode 6, oTargetID 5, oSourceID 5, oAddress 32, oLength 16, oCMDValid 1 and oWaySelect NumberOfWays, plus input iCMDReady 1, all toward the ReadStatus command block.
REQ-009 SHALL have port iCmdLastStep  in  1  completion pulse from the command block.
REQ-010 SHALL have ports iReadData in 16, iReadValid in 1, oReadReady out 1, the status-byte stream.
REQ-011 SHALL have result outputs oDone 1 (pulse), oStatus 8, oFail 1, oTimeout 1 and oPollCount 16.

Function
REQ-012 SHALL implement the states IDLE, ISSUE, WAIT, EVAL, GAP, and DONE.
REQ-013 IDLE SHALL drive oPollReady=1 and, on iPollValid, latch the payload, clear the poll counter, and move to ISSUE.
REQ-014 ISSUE SHALL drive oCMDValid=1, oOpcode=6'b000111, oTargetID={4'b0010,enhanced}, oSourceID=5'b00000 and oLength=16'd1.
REQ-015 ISSUE SHALL drive oAddress={8'h00,row} when enhanced and 32'd0 otherwise.
REQ-016 oWaySelect SHALL equal the latched way in every state except IDLE, where it is 0.
REQ-017 ISSUE SHALL move to WAIT in the cycle after iCMDReady=1 was sampled together with oCMDValid=1, and oCMDValid SHALL last exactly one cycle per poll.
REQ-018 WAIT SHALL drive oReadReady=1 and hold two flags: data-seen and last-seen.
REQ-019 In WAIT, the first iReadValid beat SHALL capture iReadData[7:0] into oStatus; later beats SHALL be accepted and discarded.
REQ-020 WAIT SHALL move to EVAL once both flags are set, in either order or in the same cycle.
REQ-021 EVAL SHALL increment oPollCount by 1 (saturating at 16'hFFFF).
REQ-022 In EVAL, if oStatus[6]=1 the block SHALL go to DONE with oFail=oStatus[0] and oTimeout=0.
REQ-023 In EVAL, if oStatus[6]=0 and the incremented count equals MaxPolls, the block SHALL go to DONE with oTimeout=1 and oFail=0.
REQ-024 In EVAL, in any other case the block SHALL go to GAP.
REQ-025 GAP SHALL count PollGap cycles and then return to ISSUE.
REQ-026 DONE SHALL pulse oDone for exactly one cycle, return to IDLE, and hold oStatus, oFail, oTimeout and oPollCount until the next request is accepted.
REQ-027 oReadReady SHALL be 0 outside WAIT.
REQ-028 iPollValid SHALL be ignored outside IDLE.

Reset
REQ-029 Asserting iReset in any state, including mid-poll, SHALL immediately force IDLE.
REQ-030 On reset, oPollReady SHALL be 1 and all other outputs, counters, flags and latched payload SHALL be 0.

Configuration
REQ-031 With macro NFC_POLL_TIMEOUT_EN defined, the MaxPolls timeout in REQ-023 SHALL apply.
REQ-032 Without NFC_POLL_TIMEOUT_EN, polling SHALL continue until oStatus[6]=1, oTimeout SHALL be tied 0, and oPollCount SHALL still saturate.

Verification
REQ-033 The bench SHALL cover: way=4'b0010, normal request, first status 8'hE0 -> one oCMDValid, oAddress=0, oTargetID=5'b00100, oDone with oStatus=E0, oFail=0, oPollCount=1.
REQ-034 The bench SHALL cover: enhanced, row=24'h012345, status 8'h00,8'h00,8'h41 -> three commands spaced by PollGap, oAddress=32'h00012345, oTargetID=5'b00101, oFail=1, oPollCount=3.
REQ-035 The bench SHALL cover: with the macro and MaxPolls=4, status always 8'h00 -> four commands, oTimeout=1, oPollCount=4; without the macro -> no oDone after 10 polls.
REQ-036 The bench SHALL cover: iReadValid arriving two cycles before iCmdLastStep, and in the same cycle as it -> EVAL entered once, oStatus is the first beat.
REQ-037 The bench SHALL cover: iReset pulsed while in WAIT -> oPollReady=1 and oCMDValid=0 next cycle, no oDone, and a new request then completes normally.
REQ-038 The bench SHALL cover: iPollValid held high through DONE -> a second poll starts only after the return to IDLE.
